// File: rtl/hippo_mem_arbiter.sv
// Purpose : two-port arbiter in front of a single-port BRAM, with per-port lock and
//           optional round-robin contention (enable by defining HIPPO_MEM_ARB_RR_EN).
// Latency : grant is combinational (same cycle); read data/rvalid one cycle after acceptance.
// Backpressure: a requester waits with req_i held until gnt_o; lock owner blocks the other port.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_i/lock_i/we_i[1:0]       per-port request, keep-ownership request, write enable
//   addr0_i/addr1_i              per-port word address
//   wdata0_i/wdata1_i            per-port write data
//   gnt_o[1:0]                   per-port grant (accept = req_i & gnt_o)
//   rvalid_o[1:0], rdata_o       per-port read valid, shared read data
//   mem_addr_o/mem_we_o/
//   mem_wdata_o/mem_rdata_i      BRAM port (read data arrives one cycle after address)
//
// Configuration macro: HIPPO_MEM_ARB_RR_EN
//   defined   : contention goes to the port that was not granted last
//   undefined : port 0 always wins contention, no pointer register exists
module hippo_mem_arbiter #(
  parameter  int BRAM_WIDTH_BITS = 8,
  parameter  int BRAM_DEPTH      = 1024,
  localparam int AddrWidth       = $clog2(BRAM_DEPTH)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [1:0]                 req_i,
  input  logic [1:0]                 lock_i,
  input  logic [1:0]                 we_i,
  input  logic [AddrWidth-1:0]       addr0_i,
  input  logic [AddrWidth-1:0]       addr1_i,
  input  logic [BRAM_WIDTH_BITS-1:0] wdata0_i,
  input  logic [BRAM_WIDTH_BITS-1:0] wdata1_i,
  output logic [1:0]                 gnt_o,
  output logic [1:0]                 rvalid_o,
  output logic [BRAM_WIDTH_BITS-1:0] rdata_o,
  output logic [AddrWidth-1:0]       mem_addr_o,
  output logic                       mem_we_o,
  output logic [BRAM_WIDTH_BITS-1:0] mem_wdata_o,
  input  logic [BRAM_WIDTH_BITS-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKED0  = 2'd1,
    ST_LOCKED1  = 2'd2
  } lock_state_t;

  lock_state_t r_state;
  logic [1:0]  r_rvalid;
  logic [1:0]  w_gnt;
  logic [1:0]  w_contend;
  logic [1:0]  w_acc;

`ifdef HIPPO_MEM_ARB_RR_EN
  // Last-granted port; contention goes to the other one.
  logic r_last;
  assign w_contend = r_last ? 2'b01 : 2'b10;
`else
  assign w_contend = 2'b01;
`endif

  // Grant decode. Reset forces grants low so nothing is accepted (and nothing
  // is written to memory) while rst_i is asserted.
  always_comb begin
    w_gnt = 2'b00;
    if (!rst_i) begin
      case (r_state)
        ST_LOCKED0: w_gnt[0] = req_i[0];
        ST_LOCKED1: w_gnt[1] = req_i[1];
        default: begin
          if (req_i == 2'b11) w_gnt = w_contend;
          else                w_gnt = req_i;
        end
      endcase
    end
  end

  assign w_acc = req_i & w_gnt;
  assign gnt_o = w_gnt;

  // Port 0 drives the memory bus whenever port 1 is not granted.
  assign mem_addr_o  = w_gnt[1] ? addr1_i  : addr0_i;
  assign mem_wdata_o = w_gnt[1] ? wdata1_i : wdata0_i;
  assign mem_we_o    = |(w_acc & we_i);

  // BRAM returns data one cycle after the address, so the shared read bus is a
  // straight pass-through qualified by the registered per-port valid.
  assign rdata_o = mem_rdata_i;

  // A read accepted just before reset must not surface while reset is held.
  assign rvalid_o = rst_i ? 2'b00 : r_rvalid;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_UNLOCKED;
      r_rvalid <= 2'b00;
`ifdef HIPPO_MEM_ARB_RR_EN
      r_last   <= 1'b0;
`endif
    end else begin
      r_rvalid <= w_acc & ~we_i;
`ifdef HIPPO_MEM_ARB_RR_EN
      if (|w_acc) r_last <= w_acc[1];
`endif
      case (r_state)
        ST_UNLOCKED: begin
          if (w_acc[0] && lock_i[0])      r_state <= ST_LOCKED0;
          else if (w_acc[1] && lock_i[1]) r_state <= ST_LOCKED1;
        end
        ST_LOCKED0: begin
          if (w_acc[0] && !lock_i[0]) r_state <= ST_UNLOCKED;
        end
        ST_LOCKED1: begin
          if (w_acc[1] && !lock_i[1]) r_state <= ST_UNLOCKED;
        end
        default: r_state <= ST_UNLOCKED;
      endcase
    end
  end

endmodule

// File: tb/tb_hippo_mem_arbiter.sv
// Purpose : self-checking bench for hippo_mem_arbiter (directed scenarios + random traffic).
// Latency : each step drives one cycle, samples outputs 3 time units after inputs settle.
// Backpressure: random requesters hold req/addr/we/wdata/lock stable until accepted.
module tb_hippo_mem_arbiter;

  localparam int W  = 8;
  localparam int D  = 1024;
  localparam int AW = $clog2(D);

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req, lock, we;
  logic [AW-1:0] addr0, addr1;
  logic [W-1:0]  wd0, wd1;
  logic [1:0]    gnt, rvalid;
  logic [W-1:0]  rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [W-1:0]  mem_wdata;
  logic [W-1:0]  mem_rd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hippo_mem_arbiter #(.BRAM_WIDTH_BITS(W), .BRAM_DEPTH(D)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .lock_i(lock), .we_i(we),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wd0), .wdata1_i(wd1),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rd)
  );

  // Small synchronous RAM behind the arbiter; traffic only uses words 0..15.
  logic [W-1:0] bram [0:15];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) bram[i] <= '0;
    end else if (mem_we) begin
      bram[mem_addr[3:0]] <= mem_wdata;
    end
    mem_rd <= bram[mem_addr[3:0]];
  end

  // Reference model: owner (-1 = nobody holds a lock), last granted port,
  // shadow memory, and the read response due next cycle.
  int           m_owner = -1;
  int           m_last  = 0;
  logic [1:0]   m_rv    = 2'b00;
  logic [1:0]   m_acc   = 2'b00;
  logic [W-1:0] m_rd    = '0;
  logic [W-1:0] shadow [0:15];

  // Samples taken during the most recent step, for directed checks.
  logic [1:0]   s_gnt, s_rv;
  logic [W-1:0] s_rd;
  logic         s_we;

  function automatic logic [1:0] model_gnt();
    if (rst) return 2'b00;
    if (m_owner == 0) return req[0] ? 2'b01 : 2'b00;
    if (m_owner == 1) return req[1] ? 2'b10 : 2'b00;
    if (req == 2'b11) begin
`ifdef HIPPO_MEM_ARB_RR_EN
      return (m_last == 0) ? 2'b10 : 2'b01;
`else
      return 2'b01;
`endif
    end
    return req;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs against the model, then advance the model.
  task automatic step();
    logic [1:0]    eg;
    logic [1:0]    acc;
    logic [AW-1:0] a;
    #3;
    eg  = model_gnt();
    acc = req & eg;
    s_gnt = gnt; s_rv = rvalid; s_rd = rdata; s_we = mem_we;
    chk("gnt", {30'd0, gnt}, {30'd0, eg});
    chk("mem_we", {31'd0, mem_we}, {31'd0, |(acc & we)});
    chk("mem_addr", {{(32-AW){1'b0}}, mem_addr}, {{(32-AW){1'b0}}, (eg[1] ? addr1 : addr0)});
    chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, (eg[1] ? wd1 : wd0)});
    chk("rvalid", {30'd0, rvalid}, {30'd0, (rst ? 2'b00 : m_rv)});
    if (!rst && m_rv != 2'b00) chk("rdata", {24'd0, rdata}, {24'd0, m_rd});
    @(posedge clk);
    if (rst) begin
      m_owner = -1; m_last = 0; m_rv = 2'b00; m_acc = 2'b00;
      for (int i = 0; i < 16; i++) shadow[i] = '0;
    end else begin
      m_acc = acc;
      m_rv  = 2'b00;
      for (int p = 0; p < 2; p++) begin
        if (acc[p]) begin
          a = (p == 1) ? addr1 : addr0;
          if (we[p]) shadow[a[3:0]] = (p == 1) ? wd1 : wd0;
          else begin
            m_rv[p] = 1'b1;
            m_rd    = shadow[a[3:0]];
          end
          m_last = p;
          if (m_owner < 0 && lock[p]) m_owner = p;
          else if (m_owner == p && !lock[p]) m_owner = -1;
        end
      end
    end
    #1;
  endtask

  initial begin
    logic [1:0] pat;
    rst = 1'b1; req = 2'b11; lock = 2'b00; we = 2'b11;
    addr0 = '0; addr1 = '0; wd0 = '0; wd1 = '0;

    // Reset: requests and writes present, nothing granted or written.
    step(); step();
    chk("rst_gnt", {30'd0, s_gnt}, 32'd0);
    chk("rst_we", {31'd0, s_we}, 32'd0);
    chk("rst_rvalid", {30'd0, s_rv}, 32'd0);

    // Single port write then read back.
    rst = 1'b0; req = 2'b01; we = 2'b01; addr0 = 10'd3; wd0 = 8'hA5;
    step();
    chk("wr_gnt", {30'd0, s_gnt}, 32'h1);
    chk("wr_we", {31'd0, s_we}, 32'h1);
    we = 2'b00;
    step();
    chk("rd_gnt", {30'd0, s_gnt}, 32'h1);
    chk("wr_no_rvalid", {30'd0, s_rv}, 32'h0);
    req = 2'b00;
    step();
    chk("rd_rvalid", {30'd0, s_rv}, 32'h1);
    chk("rd_data", {24'd0, s_rd}, 32'hA5);

    // Contention, both ports reading.
    addr0 = 10'd3; addr1 = 10'd2; we = 2'b00;
`ifdef HIPPO_MEM_ARB_RR_EN
    req = 2'b10;
    step();
    pat = 2'b10;
    req = 2'b11;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr_rvalid", {30'd0, s_rv}, {30'd0, pat});
      pat = (k % 2 == 0) ? 2'b01 : 2'b10;
      chk("rr_gnt", {30'd0, s_gnt}, {30'd0, pat});
    end
`else
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("fix_gnt", {30'd0, s_gnt}, 32'h1);
      if (k > 0) chk("fix_rvalid", {30'd0, s_rv}, 32'h1);
    end
    req = 2'b10;
    step();
    chk("fix_p1_gnt", {30'd0, s_gnt}, 32'h2);
`endif
    req = 2'b00;
    step();

    // Lock: port 1 holds ownership across a contended cycle.
    req = 2'b10; lock = 2'b10; we = 2'b00; addr1 = 10'd5;
    step();
    chk("lk_gnt0", {30'd0, s_gnt}, 32'h2);
    req = 2'b11; lock = 2'b00; we = 2'b10; wd1 = 8'h3C; addr0 = 10'd7;
    step();
    chk("lk_gnt1", {30'd0, s_gnt}, 32'h2);
    chk("lk_rvalid", {30'd0, s_rv}, 32'h2);
    req = 2'b01; we = 2'b00;
    step();
    chk("lk_gnt2", {30'd0, s_gnt}, 32'h1);
    req = 2'b00;
    step();

    // Reset right after an accepted (locking) read.
    req = 2'b01; lock = 2'b01; we = 2'b00; addr0 = 10'd3;
    step();
    rst = 1'b1; req = 2'b00; lock = 2'b00;
    step();
    chk("mrst_rvalid", {30'd0, s_rv}, 32'h0);
    chk("mrst_we", {31'd0, s_we}, 32'h0);
    req = 2'b11; we = 2'b11;
    step();
    chk("mrst_gnt", {30'd0, s_gnt}, 32'h0);
    chk("mrst_we2", {31'd0, s_we}, 32'h0);
    rst = 1'b0; req = 2'b10; we = 2'b00; addr1 = 10'd4;
    step();
    chk("mrst_unlocked", {30'd0, s_gnt}, 32'h2);
    chk("mrst_rvalid2", {30'd0, s_rv}, 32'h0);

    // Random traffic; a waiting requester keeps all its inputs stable.
    for (int n = 0; n < 600; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!(req[p] && !m_acc[p])) begin
          req[p]  = ($urandom % 4) != 0;
          we[p]   = $urandom % 2;
          lock[p] = ($urandom % 6) == 0;
          if (p == 0) begin
            addr0 = 10'($urandom_range(0, 15)); wd0 = 8'($urandom);
          end else begin
            addr1 = 10'($urandom_range(0, 15)); wd1 = 8'($urandom);
          end
        end
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
